// File: rtl/mips_multicycle_data_tract_if.sv
// Shared memory port of the multicycle datapath: one request/ack channel used by both FETCH and MEM.
interface mips_multicycle_data_tract_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mips_multicycle_data_tract.sv
// Multicycle MIPS datapath: PC/IR/A/B/ALUOut/MDR, 32x32 register file, ALU and stage FSM
// sharing one memory port, with a per-request bus timeout that parks the FSM in a sticky ERROR.
module mips_multicycle_data_tract #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_reg_dst,
  input  logic        i_reg_write,
  input  logic        i_alu_src,
  input  logic [2:0]  i_alu_op,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_to_reg,
  input  logic        i_branch,
  input  logic        i_jump,
  mips_multicycle_data_tract_if.master mem,
  output logic [31:0] o_current_instruction,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  output logic [2:0]  o_state,
  output logic        o_bus_error
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    ERROR     = 3'd7
  } state_t;

  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT);

  state_t      state;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];
  logic [31:0] tmo_cnt;

  logic        reg_dst_q, reg_write_q, alu_src_q, mem_read_q, mem_write_q, mem_to_reg_q, branch_q;
  logic [2:0]  alu_op_q;

  logic [31:0] imm_sext, alu_b, alu_res, tmo_next;
  logic [4:0]  dst;
  logic        req, tmo_hit;

  always_comb begin
    imm_sext = {{16{ir[15]}}, ir[15:0]};
    alu_b    = alu_src_q ? imm_sext : b;
    dst      = reg_dst_q ? ir[15:11] : ir[20:16];
    req      = (state == FETCH) || (state == MEM);
    tmo_next = tmo_cnt + 32'd1;
    tmo_hit  = (TMO_LIMIT != '0) && (tmo_next == TMO_LIMIT);
    case (alu_op_q)
      3'b000:  alu_res = a + alu_b;
      3'b001:  alu_res = a - alu_b;
      3'b010:  alu_res = a & alu_b;
      3'b011:  alu_res = a | alu_b;
      3'b100:  alu_res = {31'd0, $signed(a) < $signed(alu_b)};
      3'b101:  alu_res = {31'd0, a < alu_b};
      3'b110:  alu_res = a ^ alu_b;
      default: alu_res = ~(a | alu_b);
    endcase
  end

  // Request is gated by reset so an abandoned transfer drops immediately.
  assign mem.mem_req    = req && i_reset;
  assign mem.mem_we     = (state == MEM) && mem_write_q;
  assign mem.mem_addr   = (state == MEM) ? alu_out : pc;
  assign mem.mem_wdata  = b;

  assign o_current_instruction = ir;
  assign o_instr_valid         = (state == DECODE);
  assign o_pc                  = pc;
  assign o_state               = state;
  assign o_bus_error           = (state == ERROR);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      alu_out      <= '0;
      mdr          <= '0;
      tmo_cnt      <= '0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          // Ack takes priority over the timeout limit reached in the same cycle.
          if (mem.mem_ack) begin
            ir      <= mem.mem_rdata;
            pc      <= pc + 32'd4;
            tmo_cnt <= '0;
            state   <= DECODE;
          end else if (tmo_hit) begin
            state <= ERROR;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        DECODE: begin
          a            <= rf[ir[25:21]];
          b            <= rf[ir[20:16]];
          reg_dst_q    <= i_reg_dst;
          reg_write_q  <= i_reg_write;
          alu_src_q    <= i_alu_src;
          alu_op_q     <= i_alu_op;
          mem_read_q   <= i_mem_read;
          mem_write_q  <= i_mem_write;
          mem_to_reg_q <= i_mem_to_reg;
          branch_q     <= i_branch;
          if (i_jump) begin
            pc    <= {pc[31:28], ir[25:0], 2'b00};
            state <= FETCH;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          alu_out <= alu_res;
          if (branch_q) begin
            if (a == b) pc <= pc + (imm_sext << 2);
            state <= FETCH;
          end else if (mem_read_q || mem_write_q) begin
            state <= MEM;
          end else if (reg_write_q) begin
            state <= WRITEBACK;
          end else begin
            state <= FETCH;
          end
        end
        MEM: begin
          if (mem.mem_ack) begin
            tmo_cnt <= '0;
            if (mem_write_q) begin
              state <= FETCH;
            end else begin
              mdr   <= mem.mem_rdata;
              state <= WRITEBACK;
            end
          end else if (tmo_hit) begin
            state <= ERROR;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        WRITEBACK: begin
          if (reg_write_q && (dst != 5'd0)) rf[dst] <= mem_to_reg_q ? mdr : alu_out;
          state <= FETCH;
        end
        ERROR:   state <= ERROR;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_data_tract.sv
// Directed program run through the multicycle datapath with a bench-side memory responder,
// followed by a bus-timeout lockup and reset recovery.
module tb_mips_multicycle_data_tract;

  // {reg_dst, reg_write, alu_src, alu_op[2:0], mem_read, mem_write, mem_to_reg, branch, jump}
  localparam logic [10:0] C_ADDI = 11'b0_1_1_000_0_0_0_0_0;
  localparam logic [10:0] C_LW   = 11'b0_1_1_000_1_0_1_0_0;
  localparam logic [10:0] C_SW   = 11'b0_0_1_000_0_1_0_0_0;
  localparam logic [10:0] C_BEQ  = 11'b0_0_0_001_0_0_0_1_0;
  localparam logic [10:0] C_ADD  = 11'b1_1_0_000_0_0_0_0_0;
  localparam logic [10:0] C_SLT  = 11'b1_1_0_100_0_0_0_0_0;
  localparam logic [10:0] C_J    = 11'b0_0_0_000_0_0_0_0_1;

  typedef struct {
    logic [31:0] instr;
    logic [10:0] ctrl;
    logic [31:0] pc;
    int          fwait;
    logic [31:0] maddr;
    logic [31:0] mdata;
    int          mwait;
    int          cycles;
    logic [31:0] next_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump;
  logic [2:0]  alu_op;
  logic [31:0] cur_instr, pc;
  logic        instr_valid, bus_error;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  vec_t vecs [12];

  mips_multicycle_data_tract_if bus ();

  mips_multicycle_data_tract #(
    .RESET_PC (32'h0000_0100),
    .TIMEOUT  (4)
  ) dut (
    .i_clk                 (clk),
    .i_reset               (rst_n),
    .i_reg_dst             (reg_dst),
    .i_reg_write           (reg_write),
    .i_alu_src             (alu_src),
    .i_alu_op              (alu_op),
    .i_mem_read            (mem_read),
    .i_mem_write           (mem_write),
    .i_mem_to_reg          (mem_to_reg),
    .i_branch              (branch),
    .i_jump                (jump),
    .mem                   (bus),
    .o_current_instruction (cur_instr),
    .o_instr_valid         (instr_valid),
    .o_pc                  (pc),
    .o_state               (state),
    .o_bus_error           (bus_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hold a request for waits+1 cycles, checking the bus stays stable, and ack on the last one.
  task automatic serve(input string tag, input logic [31:0] addr, input logic we,
                       input logic [31:0] data, input int waits);
    for (int w = 0; w <= waits; w++) begin
      check({tag, "_req"}, 32'(bus.mem_req), 32'd1);
      check({tag, "_addr"}, bus.mem_addr, addr);
      check({tag, "_we"}, 32'(bus.mem_we), 32'(we));
      if (we) check({tag, "_wdata"}, bus.mem_wdata, data);
      bus.mem_ack   = (w == waits);
      bus.mem_rdata = (w == waits && !we) ? data : 32'h0;
      @(negedge clk);
    end
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target);
    int n = 0;
    while (state != target && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state), 32'(target));
  endtask

  initial begin
    vecs[0]  = '{32'h20010005, C_ADDI, 32'h100, 0, 32'h0, 32'h0,        0, 4, 32'h104};
    vecs[1]  = '{32'h8C220000, C_LW,   32'h104, 0, 32'h5, 32'hDEADBEEF, 3, 8, 32'h108};
    vecs[2]  = '{32'hAC020004, C_SW,   32'h108, 0, 32'h4, 32'hDEADBEEF, 0, 4, 32'h10C};
    vecs[3]  = '{32'h1000FFFF, C_BEQ,  32'h10C, 0, 32'h0, 32'h0,        0, 3, 32'h10C};
    vecs[4]  = '{32'h1020FFFF, C_BEQ,  32'h10C, 0, 32'h0, 32'h0,        0, 3, 32'h110};
    vecs[5]  = '{32'h00221820, C_ADD,  32'h110, 2, 32'h0, 32'h0,        0, 6, 32'h114};
    vecs[6]  = '{32'h0041202A, C_SLT,  32'h114, 0, 32'h0, 32'h0,        0, 4, 32'h118};
    vecs[7]  = '{32'hAC030000, C_SW,   32'h118, 0, 32'h0, 32'hDEADBEF4, 0, 4, 32'h11C};
    vecs[8]  = '{32'hAC240008, C_SW,   32'h11C, 0, 32'hD, 32'h1,        1, 5, 32'h120};
    vecs[9]  = '{32'h08000010, C_J,    32'h120, 0, 32'h0, 32'h0,        0, 2, 32'h40};
    vecs[10] = '{32'h20000007, C_ADDI, 32'h040, 0, 32'h0, 32'h0,        0, 4, 32'h44};
    vecs[11] = '{32'hAC000000, C_SW,   32'h044, 0, 32'h0, 32'h0,        0, 4, 32'h48};

    rst_n = 1'b0;
    {reg_dst, reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg, branch, jump} = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_pc", pc, 32'h100);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ir", cur_instr, 32'h0);
    check("rst_err", 32'(bus_error), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_req", 32'(bus.mem_req), 32'd1);
    check("rel_addr", bus.mem_addr, 32'h100);
    check("rel_we", 32'(bus.mem_we), 32'd0);

    foreach (vecs[i]) begin
      int c0;
      c0 = cyc;
      check($sformatf("v%0d_fetch_state", i), 32'(state), 32'd0);
      {reg_dst, reg_write, alu_src, alu_op, mem_read, mem_write, mem_to_reg, branch, jump} = vecs[i].ctrl;
      serve($sformatf("v%0d_if", i), vecs[i].pc, 1'b0, vecs[i].instr, vecs[i].fwait);
      check($sformatf("v%0d_dec_state", i), 32'(state), 32'd1);
      check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'd1);
      check($sformatf("v%0d_ir", i), cur_instr, vecs[i].instr);
      check($sformatf("v%0d_pc4", i), pc, vecs[i].pc + 32'd4);
      if (vecs[i].ctrl[4] || vecs[i].ctrl[3]) begin
        wait_state($sformatf("v%0d_mem_state", i), 3'd3);
        serve($sformatf("v%0d_mem", i), vecs[i].maddr, vecs[i].ctrl[3], vecs[i].mdata, vecs[i].mwait);
      end
      wait_state($sformatf("v%0d_back", i), 3'd0);
      check($sformatf("v%0d_cycles", i), 32'(cyc - c0), 32'(vecs[i].cycles));
      check($sformatf("v%0d_next", i), bus.mem_addr, vecs[i].next_pc);
    end

    for (int k = 0; k < 4; k++) begin
      check($sformatf("tmo_req%0d", k), 32'(bus.mem_req), 32'd1);
      @(negedge clk);
    end
    check("tmo_state", 32'(state), 32'd7);
    check("tmo_err", 32'(bus_error), 32'd1);
    check("tmo_req", 32'(bus.mem_req), 32'd0);
    check("tmo_we", 32'(bus.mem_we), 32'd0);
    bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.mem_ack = 1'b0;
    check("err_sticky", 32'(state), 32'd7);
    check("err_pc", pc, 32'h48);

    rst_n = 1'b0;
    #1;
    check("rst2_req", 32'(bus.mem_req), 32'd0);
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_pc", pc, 32'h100);
    check("rst2_err", 32'(bus_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst2_fetch_req", 32'(bus.mem_req), 32'd1);
    check("rst2_fetch_addr", bus.mem_addr, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
